// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared opcodes, ALU encodings, FSM states and control vector
//            for the multi-cycle RV32 subset controller.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Idle vector: everything off, ALU B input parked on the PC increment.
    localparam ctrl_t CTRL_RESET = ctrl_t'({9'b0, ALU_SRC_B_FOUR, ALUOP_ADD});

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R:               ok = (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_SLL);
            OP_IMM:             ok = (f3 == F3_OR);
            OP_LOAD, OP_STORE:  ok = (f3 == F3_BYTE);
            OP_BRANCH:          ok = (f3 == F3_BNE);
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ctrl_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_output_decode
// Purpose  : Combinational state -> datapath control vector decoder.
// Revision : 1.0
// ============================================================================
module ctrl_output_decode
    import cpu_pkg::*;
(
    input  state_t i_state,
    input  logic   i_wb_imm,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = ALU_SRC_B_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_RS2;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_IMM;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                // ALU controls stay as in the EXEC state so the registered ALU result is stable.
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = i_wb_imm ? ALU_SRC_B_IMM : ALU_SRC_B_RS2;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALU_SRC_B_RS2;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule : ctrl_output_decode
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_control_fsm
// Purpose  : Multi-cycle main control FSM for lb/sb/add/and/ori/sll/bne with
//            memory-wait timeout and illegal-instruction detection.
// Revision : 1.0
// ============================================================================
module main_control_fsm
    import cpu_pkg::*;
#(
    parameter int INSTR_W      = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [2:0]         funct3_out,
    output logic               illegal_instr,
    output logic               bus_error,
    output logic [3:0]         state_dbg
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST =
        WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    state_t            r_state;
    logic [2:0]        r_funct3;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_bus_error;
    logic              r_is_store;
    logic              r_wb_imm;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_legal;
    logic       w_wait_state;
    logic       w_timeout;
    logic       w_unused;
    ctrl_t      w_ctrl;
    ctrl_t      w_gated;
    ctrl_t      w_out;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_legal  = is_legal(w_opcode, w_funct3);
    assign w_unused = ^{instr[INSTR_W-1:15], instr[11:7]};

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
    assign w_timeout    = (MEM_WAIT_MAX != 0) && w_wait_state && !mem_ready &&
                          (r_wait == c_WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_funct3    <= '0;
            r_wait      <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_is_store  <= 1'b0;
            r_wb_imm    <= 1'b0;
        end else begin
            r_illegal   <= 1'b0;
            r_bus_error <= w_timeout;

            if (w_wait_state && !mem_ready && !w_timeout && (MEM_WAIT_MAX != 0))
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;

            case (r_state)
                S_FETCH: begin
                    if (mem_ready)
                        r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_funct3   <= w_funct3;
                    r_is_store <= (w_opcode == OP_STORE);
                    r_wb_imm   <= (w_opcode == OP_IMM);
                    if (!w_legal) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_FETCH;
                    end else begin
                        case (w_opcode)
                            OP_LOAD, OP_STORE: r_state <= S_MEM_ADDR;
                            OP_R:              r_state <= S_EXEC_R;
                            OP_IMM:            r_state <= S_EXEC_I;
                            default:           r_state <= S_BRANCH;
                        endcase
                    end
                end
                S_MEM_ADDR:  r_state <= r_is_store ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: begin
                    if (mem_ready)
                        r_state <= S_MEM_WB;
                    else if (w_timeout)
                        r_state <= S_FETCH;
                end
                S_MEM_WRITE: begin
                    if (mem_ready || w_timeout)
                        r_state <= S_FETCH;
                end
                S_EXEC_R, S_EXEC_I: r_state <= S_ALU_WB;
                default:            r_state <= S_FETCH;
            endcase
        end
    end

    ctrl_output_decode u_decode (
        .i_state (r_state),
        .i_wb_imm(r_wb_imm),
        .o_ctrl  (w_ctrl)
    );

    // IR load and PC increment only happen on the cycle the fetch completes.
    always_comb begin
        w_gated          = w_ctrl;
        w_gated.ir_write = w_ctrl.ir_write & mem_ready;
        w_gated.pc_write = w_ctrl.pc_write & mem_ready;
    end

    assign w_out = reset ? CTRL_RESET : w_gated;

    assign pc_write      = w_out.pc_write;
    assign pc_write_cond = w_out.pc_write_cond;
    assign iord          = w_out.iord;
    assign mem_read      = w_out.mem_read;
    assign mem_write     = w_out.mem_write;
    assign ir_write      = w_out.ir_write;
    assign mem_to_reg    = w_out.mem_to_reg;
    assign reg_write     = w_out.reg_write;
    assign alu_src_a     = w_out.alu_src_a;
    assign alu_src_b     = w_out.alu_src_b;
    assign alu_op        = w_out.alu_op;
    assign funct3_out    = reset ? 3'b000 : r_funct3;
    assign illegal_instr = r_illegal & ~reset;
    assign bus_error     = r_bus_error & ~reset;
    assign state_dbg     = r_state;

endmodule : main_control_fsm
`default_nettype wire
